can_error_signaller: RTL
========================

# can_error_signaller

CAN error-signalling and fault-confinement engine for the TinyQV CAN peripheral. The frame receiver and transmitter only detect errors. This block acts on them:
- drives the active or passive error flag and the error delimiter onto the bus;
- maintains the transmit and receive error counters (TEC/REC);
- tracks the error-active, error-passive and bus-off states, including bus-off recovery.

Its `err_tx` output is ANDed into `can_tx` by the controller top level. Its `busy` output mutes both frame state machines.

## Interface
Parameters:
- `FLAG_BITS`, default 6: length of the error flag, in bits.
- `DELIM_BITS`, default 8: length of the error delimiter, in recessive bits.
- `ECHO_MAX`, default 14: maximum number of dominant bits tolerated after our own flag before a penalty is applied.

Ports (reset is asynchronous, active-high; clock is `clk`):
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `bit_tick` input 1: one-cycle pulse at each bit boundary (bit-divider reload).
- `sample_tick` input 1: one-cycle pulse at mid-bit.
- `rx_bit` input 1: synchronized bus level; 0 means dominant.
- `rx_err` input 1: pulse; receiver detected a stuff, CRC or form error.
- `tx_err` input 1: pulse; transmitter bit error outside arbitration.
- `rx_ok` input 1: pulse; a frame was received correctly.
- `tx_ok` input 1: pulse; a frame was transmitted and acknowledged.
- `err_tx` output 1: bus drive; 0 means dominant, 1 means recessive/idle.
- `busy` output 1: high while an error frame or bus-off is in progress.
- `tec` output 9: transmit error counter.
- `rec` output 8: receive error counter, saturating at 255.
- `conf` output 2: confinement state; 00 = active, 01 = passive, 10 = bus-off.
- `irq_conf` output 1: one-cycle pulse whenever `conf` changes.

## Operation
State machine states: IDLE, PEND, FLAG, ECHO, DELIM, BUSOFF.
- **IDLE:** `rx_err` or `tx_err` moves to PEND and latches the error source.
- **PEND:** the next `bit_tick` moves to FLAG and loads the bit counter with `FLAG_BITS`.
- **FLAG:**
  - When `conf` = 00, `err_tx` = 0 (active flag).
  - When `conf` = 01, `err_tx` = 1 (passive flag).
  - The counter decrements on each `bit_tick`. When it reaches 0, the block moves to ECHO.
- **ECHO:** `err_tx` = 1.
  - At each `sample_tick`: if `rx_bit` = 1, the block moves to DELIM and the delimiter count is set to `DELIM_BITS`-1.
  - Otherwise the echo count increments. When the echo count reaches `ECHO_MAX`, the latched counter (REC, or TEC if the source was a transmitter error) is incremented by 8 and the echo count is cleared.
- **DELIM:** `err_tx` = 1.
  - At each `sample_tick` with `rx_bit` = 1, the delimiter count decrements. When it reaches 0, the block moves to IDLE.
  - `rx_bit` = 0 returns the block to ECHO, with no counter change.
- **`busy`:** high in PEND, FLAG, ECHO, DELIM and BUSOFF.
- **Errors while busy:** `rx_err` and `tx_err` are ignored while `busy` is high, so no counting happens from them.

Counter rules (applied on the pulse cycle):
- `tx_err`: TEC += 8.
- `rx_err`: REC += 1, saturating at 255.
- Simultaneous `tx_err` and `rx_err`: TEC += 8 only.
- `tx_ok`: TEC -= 1 if TEC > 0.
- `rx_ok`:
  - If REC > 127, REC is set to 119.
  - Otherwise, REC -= 1 if REC > 0.
- If an error pulse and an ok pulse arrive in the same cycle, the error wins and the ok is dropped.
- Arithmetic: TEC is 9 bits. An increment that would exceed 511 saturates at 511.

Confinement state (combinational from the counters, registered into `conf`):
- 10 (bus-off) if TEC >= 256.
- Otherwise 01 (passive) if TEC >= 128 or REC >= 128.
- Otherwise 00 (active).

Bus-off behaviour:
- Entering bus-off forces the state machine to BUSOFF from any state, with `err_tx` = 1 immediately.
- In BUSOFF, an 11-bit recessive counter (4 bits) increments at each `sample_tick` with `rx_bit` = 1.
- `rx_bit` = 0 clears the 11-bit counter only.
- Each time the 11-bit counter completes 11 bits, a 7-bit sequence counter increments.
- After 128 sequences: TEC = 0, REC = 0, `conf` = 00, and the state machine moves to IDLE.
- All `*_err` and `*_ok` inputs are ignored in BUSOFF.

## Timing
- Values after reset: `err_tx` = 1, `busy` = 0, `tec` = 0, `rec` = 0, `conf` = 00, `irq_conf` = 0, state = IDLE, all internal counters 0.
- Reset is asynchronous. If asserted in the middle of a flag, `err_tx` goes to 1 at once.
- `err_tx`, `busy` and `conf` are registered outputs.
  - `err_tx` changes in the cycle after the `bit_tick` that enters or leaves FLAG.
  - The flag therefore lasts exactly `FLAG_BITS` bit periods.
- `busy` rises in the cycle after the error pulse.
- Counters update in the cycle after the pulse.
- `conf` and `irq_conf` update one cycle after the counter update, so two cycles after the pulse.
- If `bit_tick` and the error pulse arrive in the same cycle, the error enters PEND. The flag then starts on the following `bit_tick`, not the current one.
- If `sample_tick` and `bit_tick` coincide (`bauddiv` < 2), `sample_tick` is processed first.

## Test plan
- **Active receive error:** `rx_err` pulse while active.
  - REC = 1.
  - `err_tx` is 0 for exactly 6 `bit_tick` periods, then 1.
  - With a recessive bus, `busy` falls after 8 recessive samples.
- **Passive flag:** preload TEC = 128 through 16 `tx_err` pulses (each with a full frame).
  - `conf` = 01 and `irq_conf` pulses once.
  - The next error keeps `err_tx` = 1 throughout the flag.
- **Echo timeout:** after an `rx_err`, hold `rx_bit` = 0 for 14 samples in ECHO.
  - REC = 1 + 8 = 9.
  - Releasing the bus then completes the delimiter.
- **Ok handling:** REC = 130, then an `rx_ok` pulse.
  - REC = 119 and `conf` returns to 00.
  - `tx_ok` with TEC = 0 leaves TEC = 0.
- **Bus-off:** 32 `tx_err` events.
  - TEC = 256, `conf` = 10, `busy` = 1, `err_tx` = 1.
  - Then 128×11 recessive samples with one dominant sample inserted after 5 bits: recovery occurs only after the full count, ending with TEC = REC = 0 and `conf` = 00.
- **Simultaneous events:** `rx_err`, `tx_err` and `rx_ok` in the same cycle.
  - TEC = 8, REC unchanged.
  - Reset asserted mid-flag gives `err_tx` = 1, `busy` = 0 and all counters 0.

Source files
------------

// File: rtl/can_error_signaller.sv
// CAN error-signalling and fault-confinement engine: drives error flag/delimiter,
// maintains TEC/REC and tracks active/passive/bus-off including bus-off recovery.
module can_error_signaller #(
    parameter int unsigned FLAG_BITS  = 6,
    parameter int unsigned DELIM_BITS = 8,
    parameter int unsigned ECHO_MAX   = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_tick,
    input  logic       sample_tick,
    input  logic       rx_bit,
    input  logic       rx_err,
    input  logic       tx_err,
    input  logic       rx_ok,
    input  logic       tx_ok,
    output logic       err_tx,
    output logic       busy,
    output logic [8:0] tec,
    output logic [7:0] rec,
    output logic [1:0] conf,
    output logic       irq_conf
);
    typedef enum logic [2:0] {IDLE, PEND, FLAG, ECHO, DELIM, BUSOFF} state_t;

    localparam logic [7:0] FLAG_LD   = 8'(FLAG_BITS);
    localparam logic [7:0] DELIM_LD  = 8'(DELIM_BITS - 1);
    localparam logic [7:0] ECHO_LAST = 8'(ECHO_MAX - 1);

    state_t     state;
    logic       src_tx;
    logic [7:0] bit_cnt;
    logic [7:0] delim_cnt;
    logic [7:0] echo_cnt;
    logic [3:0] bo_bits;
    logic [6:0] bo_seq;
    logic [8:0] tec_n;
    logic [7:0] rec_n;
    logic [1:0] conf_n;
    logic       err_accept;
    logic       penalty;
    logic       recover;

    function automatic logic [8:0] tec_add8(input logic [8:0] v);
        logic [9:0] s;
        s = {1'b0, v} + 10'd8;
        return s[9] ? 9'h1ff : s[8:0];
    endfunction

    function automatic logic [7:0] rec_add(input logic [7:0] v, input logic [7:0] d);
        logic [8:0] s;
        s = {1'b0, v} + {1'b0, d};
        return s[8] ? 8'hff : s[7:0];
    endfunction

    always_comb begin
        err_accept = (state == IDLE) && (rx_err || tx_err);
        penalty    = (state == ECHO) && sample_tick && !rx_bit && (echo_cnt == ECHO_LAST);
        recover    = (state == BUSOFF) && sample_tick && rx_bit &&
                     (bo_bits == 4'd10) && (bo_seq == 7'd127);
        tec_n      = tec;
        rec_n      = rec;
        // tec[8] covers the single cycle between reaching 256 and entering BUSOFF
        if (state == BUSOFF || tec[8]) begin
            if (recover) begin
                tec_n = '0;
                rec_n = '0;
            end
        end else if (err_accept) begin
            if (tx_err) tec_n = tec_add8(tec);
            else        rec_n = rec_add(rec, 8'd1);
        end else if (penalty) begin
            if (src_tx) tec_n = tec_add8(tec);
            else        rec_n = rec_add(rec, 8'd8);
        end else begin
            if (tx_ok && tec != '0) tec_n = tec - 9'd1;
            if (rx_ok) begin
                if (rec > 8'd127)    rec_n = 8'd119;
                else if (rec != '0)  rec_n = rec - 8'd1;
            end
        end
        if (tec[8])                conf_n = 2'b10;
        else if (tec[7] || rec[7]) conf_n = 2'b01;
        else                       conf_n = 2'b00;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_tx    <= 1'b0;
            bit_cnt   <= '0;
            delim_cnt <= '0;
            echo_cnt  <= '0;
            bo_bits   <= '0;
            bo_seq    <= '0;
            tec       <= '0;
            rec       <= '0;
            conf      <= 2'b00;
            irq_conf  <= 1'b0;
            err_tx    <= 1'b1;
            busy      <= 1'b0;
        end else begin
            tec      <= tec_n;
            rec      <= rec_n;
            conf     <= conf_n;
            irq_conf <= (conf_n != conf);
            if (tec[8] && state != BUSOFF) begin
                state   <= BUSOFF;
                busy    <= 1'b1;
                err_tx  <= 1'b1;
                bo_bits <= '0;
                bo_seq  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_err || tx_err) begin
                            state  <= PEND;
                            busy   <= 1'b1;
                            src_tx <= tx_err;
                        end
                    end
                    PEND: begin
                        if (bit_tick) begin
                            state   <= FLAG;
                            bit_cnt <= FLAG_LD;
                            err_tx  <= (conf != 2'b00);
                        end
                    end
                    FLAG: begin
                        err_tx <= (conf != 2'b00);
                        if (bit_tick) begin
                            if (bit_cnt <= 8'd1) begin
                                state    <= ECHO;
                                err_tx   <= 1'b1;
                                echo_cnt <= '0;
                            end else begin
                                bit_cnt <= bit_cnt - 8'd1;
                            end
                        end
                    end
                    ECHO: begin
                        err_tx <= 1'b1;
                        if (sample_tick) begin
                            if (rx_bit) begin
                                state     <= DELIM;
                                delim_cnt <= DELIM_LD;
                            end else if (echo_cnt == ECHO_LAST) begin
                                echo_cnt <= '0;
                            end else begin
                                echo_cnt <= echo_cnt + 8'd1;
                            end
                        end
                    end
                    DELIM: begin
                        err_tx <= 1'b1;
                        if (sample_tick) begin
                            if (!rx_bit) begin
                                state <= ECHO;
                            end else if (delim_cnt <= 8'd1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                delim_cnt <= delim_cnt - 8'd1;
                            end
                        end
                    end
                    BUSOFF: begin
                        err_tx <= 1'b1;
                        if (sample_tick) begin
                            if (!rx_bit) begin
                                bo_bits <= '0;
                            end else if (bo_bits == 4'd10) begin
                                bo_bits <= '0;
                                bo_seq  <= bo_seq + 7'd1;
                                if (bo_seq == 7'd127) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                end
                            end else begin
                                bo_bits <= bo_bits + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
